// File: rtl/sector_scheduler.sv
// Rotation timing and two-bank sector prefetch controller for the Hawk disk read path.
// Define SECTOR_SCHEDULER_INDEX_EN to add the once-per-revolution index output.
module sector_scheduler #(
    parameter int SECTOR_CLKS = 10000,
    parameter int NUM_SECTORS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] cyl_in,
    input  logic [1:0] hs_in,
    output logic       sector_strobe,
    output logic [4:0] sect,
    output logic       rd_en,
    output logic       bank_sel,
    output logic       fetch_req,
    output logic [4:0] fetch_sect,
    output logic [8:0] fetch_cyl,
    output logic [1:0] fetch_hs,
    output logic       fetch_bank,
    input  logic       fetch_done,
`ifdef SECTOR_SCHEDULER_INDEX_EN
    output logic       index,
`endif
    output logic       underrun
);

    localparam int            CW        = $clog2(SECTOR_CLKS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SECTOR_CLKS - 1);
    localparam logic [4:0]    SECT_LAST = 5'(NUM_SECTORS - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [CW-1:0]    cnt;
    logic [4:0]       tgt;
    logic [1:0]       valid;
    logic [1:0][15:0] tag;
    logic [0:0]       state;
    logic [8:0]       cyl_q;
    logic [1:0]       hs_q;

    logic             boundary;
    logic             geo_change;
    logic             done_ok;
    logic             tgt_hit;
    logic             rd_hit;
    logic [4:0]       sect_next;
    logic [4:0]       tgt_next;
    logic [1:0]       valid_upd;
    logic [1:0]       valid_nxt;
    logic [1:0][15:0] tag_upd;

    assign boundary   = (cnt == CNT_LAST);
    assign geo_change = (cyl_in != cyl_q) || (hs_in != hs_q);
    assign sect_next  = (sect == SECT_LAST) ? 5'd0 : sect + 5'd1;
    assign tgt_next   = (sect_next == SECT_LAST) ? 5'd0 : sect_next + 5'd1;

    // A completion only counts if it still matches what we want next; stale
    // results (geometry moved, or the sector already rotated past) are dropped.
    assign done_ok = (state == ST_REQ) && fetch_done &&
                     ({fetch_sect, fetch_cyl, fetch_hs} == {tgt, cyl_in, hs_in});

    assign tgt_hit = valid[tgt[0]] && (tag[tgt[0]] == {tgt, cyl_in, hs_in});

    always_comb begin
        valid_upd = valid;
        tag_upd   = tag;
        if (done_ok) begin
            valid_upd[fetch_bank] = 1'b1;
            tag_upd[fetch_bank]   = {fetch_sect, fetch_cyl, fetch_hs};
        end
        valid_nxt = valid_upd;
        if (boundary) begin
            valid_nxt[~sect_next[0]] = 1'b0;
        end
        if (geo_change) begin
            valid_nxt = 2'b00;
        end
    end

    // Readability of the incoming sector sees a completion landing on this very cycle.
    assign rd_hit = valid_upd[sect_next[0]] &&
                    (tag_upd[sect_next[0]] == {sect_next, cyl_in, hs_in}) &&
                    !geo_change;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            sect          <= SECT_LAST;
            tgt           <= 5'd0;
            sector_strobe <= 1'b0;
            underrun      <= 1'b0;
            rd_en         <= 1'b0;
        end else begin
            cnt           <= boundary ? '0 : cnt + CW'(1);
            sector_strobe <= boundary;
            underrun      <= boundary && !rd_hit;
            if (boundary) begin
                sect  <= sect_next;
                tgt   <= tgt_next;
                rd_en <= rd_hit;
            end else if (geo_change) begin
                rd_en <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 2'b00;
            tag   <= '0;
            cyl_q <= 9'd0;
            hs_q  <= 2'd0;
        end else begin
            valid <= valid_nxt;
            tag   <= tag_upd;
            cyl_q <= cyl_in;
            hs_q  <= hs_in;
        end
    end

    // Host handshake: fetch_req rises with fetch_* stable and stays up until the
    // host returns a one-cycle fetch_done; fetch_req drops the next cycle and the
    // request is never withdrawn early.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            fetch_sect <= 5'd0;
            fetch_cyl  <= 9'd0;
            fetch_hs   <= 2'd0;
            fetch_bank <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!tgt_hit && !boundary) begin
                        state      <= ST_REQ;
                        fetch_sect <= tgt;
                        fetch_cyl  <= cyl_in;
                        fetch_hs   <= hs_in;
                        fetch_bank <= tgt[0];
                    end
                end
                ST_REQ: begin
                    if (fetch_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fetch_req = (state == ST_REQ);
    assign bank_sel  = sect[0];

`ifdef SECTOR_SCHEDULER_INDEX_EN
    localparam logic [CW-1:0] IDX_LAST = CW'(SECTOR_CLKS / 8 - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= 1'b0;
        end else if (boundary) begin
            index <= (sect_next == 5'd0);
        end else if (cnt == IDX_LAST) begin
            index <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/sector_scheduler.md
Name: sector_scheduler

Overview:
- Rotation timing and prefetch controller for the Hawk disk read path.
- Models platter rotation: emits the per-sector strobe and current sector number consumed by the Read serializer.
- Schedules host fetches of upcoming sectors into a two-bank sector buffer, one bank per sector parity. Read streams from one bank while the other bank is filled.
- Gates rd_en so that only sectors fully fetched for the current cylinder/head are read.

Parameters:
- SECTOR_CLKS, 10000: clk cycles per sector period; minimum 16.
- NUM_SECTORS, 16: sectors per track; must be even and ≤ 32.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cyl_in  in  9  current cylinder from seek logic
- hs_in  in  2  current head/surface select
- sector_strobe  out  1  one-cycle pulse at each sector start
- sect  out  5  sector number now under the head; stable for the whole sector
- rd_en  out  1  current sector buffer is valid; Read may serialize it
- bank_sel  out  1  buffer bank Read addresses; always equals sect[0]
- fetch_req  out  1  request to the host to load one sector
- fetch_sect  out  5  sector to load
- fetch_cyl  out  9  cylinder to load
- fetch_hs  out  2  head to load
- fetch_bank  out  1  destination bank; equals fetch_sect[0]
- fetch_done  in  1  one-cycle completion pulse from the host
- underrun  out  1  one-cycle pulse: sector started without valid data

Behaviour:
- Reset (async) values:
  - cnt=0, tgt=0, valid[1:0]=0, fetch FSM IDLE.
  - Outputs sector_strobe=0, sect=NUM_SECTORS-1, rd_en=0, bank_sel=sect[0], fetch_req=0, fetch_* =0, underrun=0.
- Rotation counter:
  - cnt increments every cycle and wraps from SECTOR_CLKS-1 to 0.
  - On the cycle cnt==SECTOR_CLKS-1 (the boundary), the registered outputs updated on the next edge are:
    - sector_strobe=1 for that cycle only.
    - sect=(sect+1) mod NUM_SECTORS, call it S.
    - rd_en=valid[S[0]] && tag[S[0]]=={S,cyl_in,hs_in}.
    - underrun=!rd_en for that cycle only.
    - tgt=(S+1) mod NUM_SECTORS.
    - valid[S[0]^1] cleared, because that bank is freed.
  - First strobe after reset release occurs exactly SECTOR_CLKS cycles later, with sect=0.
- rd_en:
  - Held for the whole sector.
  - Cleared the cycle after any change of cyl_in or hs_in, then stays 0 until the next boundary.
- Geometry change (cyl_in/hs_in differ from the previous cycle):
  - Both valid bits cleared.
  - Any outstanding fetch completes but is discarded.
- Fetch FSM, states IDLE, REQ:
  - IDLE→REQ when !(valid[tgt[0]] && tag matches {tgt,cyl_in,hs_in}) and no boundary this cycle.
  - On entering REQ, fetch_sect/cyl/hs/bank are latched from tgt/cyl_in/hs_in.
  - In REQ, fetch_req=1 and the fetch_* outputs stay stable until fetch_done.
  - REQ→IDLE on fetch_done; fetch_req=0 on the next cycle.
  - On fetch_done, valid[fetch_bank]=1 and tag is set only if {fetch_sect,fetch_cyl,fetch_hs}=={tgt,cyl_in,hs_in}; otherwise the result is discarded.
  - A fetch is never aborted.
  - A new request is issued no earlier than one cycle after fetch_done.
- Simultaneous events:
  - fetch_done on the boundary cycle: the completion is compared against the old tgt, and valid is set before the rd_en evaluation. A sector finishing on its own boundary is readable.
  - Geometry change on the boundary cycle takes priority: rd_en=0 and underrun=1.
  - fetch_done while IDLE is ignored.

Optional Feature:
- Macro: SECTOR_SCHEDULER_INDEX_EN.
- Defined:
  - Adds output port index (1 bit), reset 0.
  - index=1 for the first SECTOR_CLKS/8 cycles of sector 0, starting with the strobe cycle.
- Undefined:
  - Port and logic are absent; all other behaviour is identical.

Test Plan (SECTOR_CLKS=64, NUM_SECTORS=4):
- Reset release, host acks each fetch 10 cycles after fetch_req:
  - fetch_req rises cycle 1 with fetch_sect=0, fetch_bank=0.
  - First strobe at cycle 64 with sect=0, rd_en=1, underrun=0.
  - Next fetch has sect=1, bank=1.
- Steady rotation for 8 sectors:
  - sect sequence 0,1,2,3,0,1,2,3.
  - Strobe spacing is exactly 64 cycles; bank_sel==sect[0]; rd_en=1 throughout.
- Host withholds fetch_done for sector 2 for 100 cycles:
  - Strobe for sect=2 gives rd_en=0 and a single underrun pulse.
  - The late completion is discarded (tgt is now 3).
  - Sector 3 fetch follows; rd_en=1 at sect=3 if done in time.
- cyl_in changes 9'h0D4→9'h0D5 mid-sector 1:
  - rd_en=0 next cycle and for the remainder of sector 1.
  - Pending fetch tagged 0D4 is discarded; a refetch with fetch_cyl=0D5 is issued.
- fetch_done asserted on the boundary cycle for sector 1:
  - Strobe with sect=1 gives rd_en=1, no underrun.
- rst asserted mid-REQ:
  - All outputs return to reset values immediately (async).
  - After release, the sequence matches the first scenario.
